// File: rtl/tx_fifo_top.sv
// Button-triggered UART transmitter with FIFO, debouncer and 2-flop synchronizers.
// Optional sticky overflow flag on LED17_R enabled by macro TX_FIFO_OVERFLOW_EN.
module tx_fifo_top #(
  parameter int CLK_FREQUENCY    = 100_000_000,
  parameter int BAUD_RATE        = 19_200,
  parameter int DATA_BITS        = 8,
  parameter int PARITY_MODE      = 1,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 8,
  parameter int DEBOUNCE_TIME_US = 100
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic [7:0] SW,
  input  logic       BTNC,
  output logic [7:0] LED,
  output logic       LED16_B,
  output logic       LED17_G,
  output logic       LED17_R,
  output logic       UART_RXD_OUT
);

  localparam int BIT_CLKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int DB_CLKS  = CLK_FREQUENCY / 1_000_000 * DEBOUNCE_TIME_US;
  localparam int BW       = $clog2(BIT_CLKS + 1);
  localparam int DW       = $clog2(DB_CLKS + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [7:0]           r_sw_s1, r_sw_s2, r_led;
  logic                 r_btn_s1, r_btn_s2;
  logic                 r_db, r_db_q, r_boot, r_armed;
  logic [DW-1:0]        r_dbc;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wptr, r_rptr;
  state_t               r_state, w_state_n;
  logic [BW-1:0]        r_baud, w_baud_n;
  logic [2:0]           r_bit, w_bit_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_par, w_par_n;
  logic                 r_txd, w_txd_n;
  logic                 w_push_req, w_push, w_pop, w_load, w_tick;
  logic                 w_empty, w_full;
  logic [DATA_BITS-1:0] w_rdata;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_led    <= '0;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_sw_s1  <= SW;
      r_sw_s2  <= r_sw_s1;
      r_led    <= r_sw_s2;
      r_btn_s1 <= BTNC;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Arm only once the real button level is seen low after reset,
  // so a button held through reset never yields a push.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_db    <= 1'b0;
      r_db_q  <= 1'b0;
      r_dbc   <= '0;
      r_boot  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_db_q <= r_db;
      r_boot <= 1'b1;
      if (r_boot && !r_btn_s1 && !r_btn_s2)
        r_armed <= 1'b1;
      if (r_btn_s2 == r_db) begin
        r_dbc <= '0;
      end else if (r_dbc == DW'(DB_CLKS - 1)) begin
        r_db  <= r_btn_s2;
        r_dbc <= '0;
      end else begin
        r_dbc <= r_dbc + 1'b1;
      end
    end
  end

  assign w_push_req = r_db & ~r_db_q & r_armed;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge CLK100MHZ) begin
    if (w_push)
      r_mem[r_wptr[AW-1:0]] <= r_sw_s2[DATA_BITS-1:0];
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_txd   <= w_txd_n;
    end
  end

  // Line value is computed for the next state so the register stays aligned.
  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_txd_n   = r_txd;
    w_pop     = 1'b0;
    w_load    = 1'b0;
    w_tick    = (r_baud == BW'(BIT_CLKS - 1));
    if (r_state != S_IDLE)
      w_baud_n = w_tick ? '0 : r_baud + 1'b1;
    unique case (r_state)
      S_IDLE: w_load = !w_empty;
      S_START: begin
        if (w_tick) begin
          w_state_n = S_DATA;
          w_txd_n   = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit == 3'(DATA_BITS - 1)) begin
            w_bit_n = '0;
            if (PARITY_MODE != 0) begin
              w_state_n = S_PARITY;
              w_txd_n   = r_par;
            end else begin
              w_state_n = S_STOP;
              w_txd_n   = 1'b1;
            end
          end else begin
            w_bit_n   = r_bit + 1'b1;
            w_shift_n = r_shift >> 1;
            w_txd_n   = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_n = S_STOP;
          w_txd_n   = 1'b1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_bit == 3'(STOP_BITS - 1)) begin
            w_bit_n = '0;
            w_load  = !w_empty;
            if (w_empty) begin
              w_state_n = S_IDLE;
              w_txd_n   = 1'b1;
            end
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_load) begin
      w_pop     = 1'b1;
      w_state_n = S_START;
      w_shift_n = w_rdata;
      w_par_n   = (^w_rdata) ^ (PARITY_MODE == 2);
      w_txd_n   = 1'b0;
      w_baud_n  = '0;
      w_bit_n   = '0;
    end
  end

`ifdef TX_FIFO_OVERFLOW_EN
  logic r_ovf;
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)
      r_ovf <= 1'b0;
    else if (w_push_req && !w_push)
      r_ovf <= 1'b1;
  end
  assign LED17_R = r_ovf;
`else
  assign LED17_R = 1'b0;
`endif

  assign LED          = r_led;
  assign LED16_B      = (r_state != S_IDLE);
  assign LED17_G      = w_full;
  assign UART_RXD_OUT = r_txd;

endmodule
